// File: rtl/mux_n_to_1_reg.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_reg
//   Parametrised N-way, WIDTH-bit registered selector with a valid/ready
//   handshake on every input channel and on the output. A beat is chosen either
//   by an explicit select (mode=0) or round-robin over the valid channels
//   (mode=1), and is held in a single output register. The register reloads on
//   the same edge it drains, so back-to-back beats flow without a bubble.
//
// Parameters
//   WIDTH  data width per channel (>=1)
//   N_IN   number of input channels (>=2)
//   SEL_W  derived select / source-index width, $clog2(N_IN)
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_data    packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, 0 while reset_n=0)
//   sel        explicit channel select, used when mode=0
//   mode       0 = explicit select, 1 = round-robin over valid channels
//   out_data   registered data of the accepted channel
//   out_src    index of the channel that supplied out_data
//   out_valid  out_data/out_src hold a beat
//   out_ready  consumer accepts the beat when out_valid && out_ready
//   out_parity (only with MUX_PARITY_EN) XOR reduction of out_data
//
// Build option
//   MUX_PARITY_EN  adds the registered out_parity output
// -----------------------------------------------------------------------------
module mux_n_to_1_reg #(
  parameter int  WIDTH = 32,
  parameter int  N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  output logic                  out_valid,
`ifdef MUX_PARITY_EN
  output logic                  out_parity,
`endif
  input  logic                  out_ready
);

`ifdef MUX_PARITY_EN
  function automatic logic parity_f(input logic [WIDTH-1:0] d);
    parity_f = ^d;
  endfunction
`endif

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef MUX_PARITY_EN
  logic             out_parity_q, out_parity_d;
`endif

  logic             can_load_s;
  logic             rr_found_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic             grant_vld_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             grant_in_valid_s;
  logic             accept_s;

  // Output register can take a new beat when empty or draining this cycle.
  assign can_load_s = !out_valid_q || out_ready;

  // Round-robin search: channels above rr_ptr first, then wrap to 0..rr_ptr.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = {SEL_W{1'b0}};
    for (int k = 0; k < N_IN; k++) begin
      if (!rr_found_s && in_valid[k] && (k > int'(rr_ptr_q))) begin
        rr_found_s = 1'b1;
        rr_idx_s   = SEL_W'(k);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
    for (int k = 0; k < N_IN; k++) begin
      if (!rr_found_s && in_valid[k] && (k <= int'(rr_ptr_q))) begin
        rr_found_s = 1'b1;
        rr_idx_s   = SEL_W'(k);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant source: explicit select (unused codes grant nothing) or round-robin.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {SEL_W{1'b0}};
    if (mode) begin
      grant_vld_s = rr_found_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_vld_s = (int'(sel) < N_IN);
      grant_idx_s = sel;
    end
  end

  // Data mux and per-channel ready; only the granted channel sees ready.
  always_comb begin
    grant_data_s     = {WIDTH{1'b0}};
    grant_in_valid_s = 1'b0;
    in_ready         = {N_IN{1'b0}};
    for (int k = 0; k < N_IN; k++) begin
      if (grant_vld_s && (grant_idx_s == SEL_W'(k))) begin
        grant_data_s     = in_data[k*WIDTH +: WIDTH];
        grant_in_valid_s = in_valid[k];
        in_ready[k]      = reset_n && can_load_s;
      end else begin
        in_ready[k]      = 1'b0;
      end
    end
  end

  assign accept_s = reset_n && can_load_s && grant_vld_s && grant_in_valid_s;

  // Next-state: load on accept, drop valid on a drain with no refill, else hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef MUX_PARITY_EN
    out_parity_d = out_parity_q;
`endif
    if (accept_s) begin
      out_data_d  = grant_data_s;
      out_src_d   = grant_idx_s;
      out_valid_d = 1'b1;
`ifdef MUX_PARITY_EN
      out_parity_d = parity_f(grant_data_s);
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    // Pointer only advances on round-robin accepts; explicit accepts leave it.
    if (accept_s && mode) begin
      rr_ptr_d = grant_idx_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data_q  <= {WIDTH{1'b0}};
      out_src_q   <= {SEL_W{1'b0}};
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(N_IN - 1);
`ifdef MUX_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
`ifdef MUX_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Testbench for mux_n_to_1_reg: a 4x32 instance (A) and a 3x8 instance (B,
// non-power-of-2 channel count). Directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural reference model.
module tb_mux_n_to_1_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid, a_in_ready;
  logic [1:0]   a_sel, a_out_src;
  logic         a_mode, a_out_valid, a_out_ready;
  logic [31:0]  a_out_data;

  logic [23:0]  b_in_data;
  logic [2:0]   b_in_valid, b_in_ready;
  logic [1:0]   b_sel, b_out_src;
  logic         b_mode, b_out_valid, b_out_ready;
  logic [7:0]   b_out_data;

`ifdef MUX_PARITY_EN
  logic a_out_parity, b_out_parity;
`endif

  mux_n_to_1_reg #(.WIDTH(32), .N_IN(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
    .out_src(a_out_src), .out_valid(a_out_valid),
`ifdef MUX_PARITY_EN
    .out_parity(a_out_parity),
`endif
    .out_ready(a_out_ready)
  );

  mux_n_to_1_reg #(.WIDTH(8), .N_IN(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
    .out_src(b_out_src), .out_valid(b_out_valid),
`ifdef MUX_PARITY_EN
    .out_parity(b_out_parity),
`endif
    .out_ready(b_out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [31:0] base;      // channel k data = base + k
    logic [3:0]  exp_rdy;   // in_ready before the edge
    logic        exp_ov;    // outputs after the edge
    logic [1:0]  exp_src;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                              input logic [3:0] v, input logic o, input logic [31:0] b,
                              input logic [3:0] er, input logic eo, input logic [1:0] es,
                              input logic [31:0] ed);
    vec_t t;
    t.rst_n = r; t.mode = m; t.sel = s; t.vld = v; t.ordy = o; t.base = b;
    t.exp_rdy = er; t.exp_ov = eo; t.exp_src = es; t.exp_data = ed;
    return t;
  endfunction

  task automatic set_a_data(input logic [31:0] base);
    for (int k = 0; k < 4; k++) a_in_data[k*32 +: 32] = base + 32'(k);
  endtask

  // Reference grant: explicit index, or first valid channel after rr (mod n).
  function automatic int ref_grant(input bit mode, input int sel, input int vld,
                                   input int rr, input int n);
    if (!mode) return (sel < n) ? sel : -1;
    for (int i = 1; i <= n; i++) begin
      int k;
      k = (rr + i) % n;
      if (((vld >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  // One cycle of the reference: expected ready from the current state, then next state.
  task automatic model_step(input int n, input bit rst, input bit mode, input int sel,
                            input int vld, input bit ordy, input logic [31:0] ch[4],
                            inout bit v, inout logic [31:0] d, inout int src,
                            inout bit par, inout int rr, output int exp_rdy);
    bit can;
    int g;
    if (!rst) begin
      v = 1'b0; d = 32'd0; src = 0; par = 1'b0; rr = n - 1; exp_rdy = 0;
    end else begin
      can = !v || ordy;
      g = ref_grant(mode, sel, vld, rr, n);
      exp_rdy = (g >= 0 && can) ? (1 << g) : 0;
      if (g >= 0 && can && (((vld >> g) & 1) != 0)) begin
        d = ch[g]; src = g; v = 1'b1; par = ^ch[g];
        if (mode) rr = g;
      end else if (v && ordy) begin
        v = 1'b0;
      end
    end
  endtask

  task automatic b_step(input logic r, input logic m, input logic [1:0] s, input logic [2:0] v,
                        input logic o, input logic [2:0] er, input logic eo,
                        input logic [1:0] es, input logic [7:0] ed, input string nm);
    reset_n = r; b_mode = m; b_sel = s; b_in_valid = v; b_out_ready = o;
    #2;
    chk({nm, "_rdy"}, 64'(b_in_ready), 64'(er));
    @(posedge clk); #1;
    chk({nm, "_ov"}, 64'(b_out_valid), 64'(eo));
    chk({nm, "_src"}, 64'(b_out_src), 64'(es));
    chk({nm, "_data"}, 64'(b_out_data), 64'(ed));
  endtask

`ifdef MUX_PARITY_EN
  task automatic par_step(input logic r, input logic [31:0] d1, input logic o,
                          input logic eo, input logic ep, input string nm);
    reset_n = r; a_mode = 1'b0; a_sel = 2'd1; a_in_valid = 4'b0010; a_out_ready = o;
    a_in_data[63:32] = d1;
    #2;
    @(posedge clk); #1;
    chk({nm, "_ov"}, 64'(a_out_valid), 64'(eo));
    chk({nm, "_par"}, 64'(a_out_parity), 64'(ep));
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    a_in_data = 128'd0; a_in_valid = 4'd0; a_sel = 2'd0; a_mode = 1'b0; a_out_ready = 1'b0;
    b_in_data = 24'd0;  b_in_valid = 3'd0; b_sel = 2'd0; b_mode = 1'b0; b_out_ready = 1'b0;

    // ---------------- directed vector table on A ----------------
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 4'hF, 1'b1, 32'h100, 4'h0, 1'b0, 2'd0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 4'hF, 1'b1, 32'h100, 4'h0, 1'b0, 2'd0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 32'hDEADBEED, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 1'b0, 2'd1, 4'hF, 1'b0, 32'h1000, 4'h0, 1'b1, 2'd2, 32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 1'b0, 2'd3, 4'hF, 1'b0, 32'h2000, 4'h0, 1'b1, 2'd2, 32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 1'b0, 2'd0, 4'hF, 1'b0, 32'h3000, 4'h0, 1'b1, 2'd2, 32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 1'b0, 2'd1, 4'hF, 1'b1, 32'h4000, 4'b0010, 1'b1, 2'd1, 32'h4001));
    vecs.push_back(mk(1'b1, 1'b0, 2'd3, 4'h0, 1'b1, 32'h5000, 4'b1000, 1'b0, 2'd1, 32'h4001));
    vecs.push_back(mk(1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 32'h6000, 4'b0001, 1'b1, 2'd0, 32'h6000));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 32'h7000, 4'(1 << (i % 4)), 1'b1,
                        2'(i % 4), 32'h7000 + 32'(i % 4)));
    for (int i = 0; i < 4; i++) begin
      int s;
      s = (i % 2 == 1) ? 3 : 1;
      vecs.push_back(mk(1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 32'h7000, 4'(1 << s), 1'b1,
                        2'(s), 32'h7000 + 32'(s)));
    end
    vecs.push_back(mk(1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 32'h7000, 4'b0100, 1'b1, 2'd2, 32'h7002));
    vecs.push_back(mk(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 32'h7000, 4'b0001, 1'b1, 2'd0, 32'h7000));
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 32'h7000, 4'h0, 1'b0, 2'd0, 32'h0));

    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n; a_mode = vecs[i].mode; a_sel = vecs[i].sel;
      a_in_valid = vecs[i].vld; a_out_ready = vecs[i].ordy;
      set_a_data(vecs[i].base);
      #2;
      chk($sformatf("tbl%0d_rdy", i), 64'(a_in_ready), 64'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_ov", i), 64'(a_out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("tbl%0d_src", i), 64'(a_out_src), 64'(vecs[i].exp_src));
      chk($sformatf("tbl%0d_data", i), 64'(a_out_data), 64'(vecs[i].exp_data));
    end

    // ---------------- B: 3 channels, unused select code, wrap ----------------
    b_in_data = {8'h33, 8'h22, 8'h11};
    b_step(1'b0, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 8'h00, "b_rst");
    b_step(1'b1, 1'b0, 2'd1, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 8'h22, "b_sel1");
    b_step(1'b1, 1'b0, 2'd3, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 8'h22, "b_sel3_stall");
    b_step(1'b1, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 2'd1, 8'h22, "b_sel3_drain");
    b_step(1'b1, 1'b1, 2'd3, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 8'h11, "b_rr_wrap");
    b_step(1'b1, 1'b1, 2'd3, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 8'h11, "b_rr_single");
    b_step(1'b1, 1'b1, 2'd0, 3'b100, 1'b1, 3'b100, 1'b1, 2'd2, 8'h33, "b_rr_ch2");
    b_step(1'b1, 1'b1, 2'd0, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 8'h11, "b_rr_wrap2");

`ifdef MUX_PARITY_EN
    // ---------------- parity on A ----------------
    par_step(1'b0, 32'h7, 1'b1, 1'b0, 1'b0, "par_rst");
    par_step(1'b1, 32'h7, 1'b1, 1'b1, 1'b1, "par_7");
    par_step(1'b1, 32'h3, 1'b1, 1'b1, 1'b0, "par_3");
    par_step(1'b1, 32'h7, 1'b1, 1'b1, 1'b1, "par_7b");
    par_step(1'b1, 32'h3, 1'b0, 1'b1, 1'b1, "par_stall");
    par_step(1'b0, 32'h3, 1'b0, 1'b0, 1'b0, "par_rst_mid");
`endif

    // ---------------- randomized traffic vs. reference model ----------------
    begin
      bit ma_v, mb_v, ma_p, mb_p;
      logic [31:0] ma_d, mb_d;
      int ma_src, mb_src, ma_rr, mb_rr, ea_rdy, eb_rdy;
      logic [31:0] cha[4];
      logic [31:0] chb[4];
      bit rst;
      ma_v = 1'b0; mb_v = 1'b0; ma_p = 1'b0; mb_p = 1'b0; ma_d = 32'd0; mb_d = 32'd0;
      ma_src = 0; mb_src = 0; ma_rr = 3; mb_rr = 2;
      for (int it = 0; it < 600; it++) begin
        rst = (it == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
        reset_n = rst;
        // Mode is held for bursts so round-robin sequences develop.
        if ($urandom_range(0, 7) == 0) a_mode = ~a_mode;
        if ($urandom_range(0, 7) == 0) b_mode = ~b_mode;
        a_sel = 2'($urandom_range(0, 3));
        b_sel = 2'($urandom_range(0, 3));
        a_in_valid = 4'($urandom_range(0, 15));
        b_in_valid = 3'($urandom_range(0, 7));
        a_out_ready = ($urandom_range(0, 3) != 0);
        b_out_ready = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) begin
          cha[k] = $urandom;
          a_in_data[k*32 +: 32] = cha[k];
          chb[k] = 32'($urandom_range(0, 255));
          if (k < 3) b_in_data[k*8 +: 8] = chb[k][7:0];
        end
        model_step(4, rst, a_mode, int'(a_sel), int'(a_in_valid), a_out_ready, cha,
                   ma_v, ma_d, ma_src, ma_p, ma_rr, ea_rdy);
        model_step(3, rst, b_mode, int'(b_sel), int'(b_in_valid), b_out_ready, chb,
                   mb_v, mb_d, mb_src, mb_p, mb_rr, eb_rdy);
        #2;
        chk($sformatf("rnd%0d_a_rdy", it), 64'(a_in_ready), 64'(ea_rdy));
        chk($sformatf("rnd%0d_b_rdy", it), 64'(b_in_ready), 64'(eb_rdy));
        @(posedge clk); #1;
        chk($sformatf("rnd%0d_a_ov", it), 64'(a_out_valid), 64'(ma_v));
        chk($sformatf("rnd%0d_a_src", it), 64'(a_out_src), 64'(ma_src));
        chk($sformatf("rnd%0d_a_data", it), 64'(a_out_data), 64'(ma_d));
        chk($sformatf("rnd%0d_b_ov", it), 64'(b_out_valid), 64'(mb_v));
        chk($sformatf("rnd%0d_b_src", it), 64'(b_out_src), 64'(mb_src));
        chk($sformatf("rnd%0d_b_data", it), 64'(b_out_data), 64'(mb_d[7:0]));
`ifdef MUX_PARITY_EN
        chk($sformatf("rnd%0d_a_par", it), 64'(a_out_parity), 64'(ma_p));
        chk($sformatf("rnd%0d_b_par", it), 64'(b_out_parity), 64'(mb_p));
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
